// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter slice.
// Execution units hand results to the CDB as tag + value pairs.
package cdb_arbiter_pkg;

    localparam int NUM_REQ  = 4;
    localparam int NUM_TAGS = 8;
    localparam int TAG_W    = $clog2(NUM_TAGS);
    localparam int DATA_W   = 32;
    localparam int SRC_W    = $clog2(NUM_REQ);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_req_t;

    function automatic logic [NUM_TAGS-1:0] tag_onehot(input logic [TAG_W-1:0] tag);
        return NUM_TAGS'(1) << tag;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between the execution units and the CDB arbiter.
// The master side is the unit cluster; the slave side is the arbiter.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic                flush;
    logic [NUM_REQ-1:0]  req_valid;
    cdb_req_t            req [NUM_REQ];
    logic [NUM_REQ-1:0]  req_ready;
    logic                bcast_valid;
    logic [TAG_W-1:0]    bcast_tag;
    logic [DATA_W-1:0]   bcast_data;
    logic [SRC_W-1:0]    bcast_src;
    logic [NUM_TAGS-1:0] cdb_enable;

    modport master (
        output flush, req_valid, req,
        input  req_ready, bcast_valid, bcast_tag, bcast_data, bcast_src, cdb_enable
    );

    modport slave (
        input  flush, req_valid, req,
        output req_ready, bcast_valid, bcast_tag, bcast_data, bcast_src, cdb_enable
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The wrap is an explicit compare so N need not be a power of two.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_grant
);

    always_comb begin : pick
        int idx;
        logic [PTR_W-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = PTR_W'(idx);
            if (!any_grant && req[sel]) begin
                any_grant  = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// One-entry result slots per execution unit, drained onto the CDB one per cycle
// in round-robin order. Broadcast outputs come straight from the granted slot.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input logic          clk,
    input logic          rst,
    cdb_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0] slot_valid;
    cdb_req_t           slot [NUM_REQ];
    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               any_grant;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] capture;
    logic               bcast_go;
    logic               dup_tags;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(SRC_W)) u_rr (
        .req       (slot_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // A slot being drained this cycle can take a new result in the same cycle.
    assign ready         = ~slot_valid | grant;
    assign capture       = bus.req_valid & ready & {NUM_REQ{~bus.flush}};
    assign bus.req_ready = ready;

    always_comb begin
        bcast_go        = any_grant & ~bus.flush;
        bus.bcast_valid = bcast_go;
        bus.bcast_tag   = '0;
        bus.bcast_data  = '0;
        bus.bcast_src   = '0;
        bus.cdb_enable  = '0;
        if (bcast_go) begin
            bus.bcast_tag  = slot[grant_idx].tag;
            bus.bcast_data = slot[grant_idx].data;
            bus.bcast_src  = grant_idx;
            bus.cdb_enable = tag_onehot(slot[grant_idx].tag);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.flush) begin
                    slot_valid[i] <= 1'b0;
                end else if (capture[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot[i]       <= bus.req[i];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (bcast_go) begin
            rr_ptr <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : SRC_W'(grant_idx + 1'b1);
        end
    end

    // Two live slots carrying the same ROB tag means the issue logic upstream is broken.
    always_comb begin
        dup_tags = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = i + 1; j < NUM_REQ; j++)
                if (slot_valid[i] && slot_valid[j] && slot[i].tag == slot[j].tag)
                    dup_tags = 1'b1;
    end

    assert property (@(posedge clk) disable iff (rst) !dup_tags);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus queues expected broadcasts with their
// cycle; a negedge monitor pops and compares whenever the CDB carries a result.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  src;
        int                cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   now;
    int   base;
    int   check_count;
    int   pass_count;
    exp_t exp_q [$];

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic fl);
        bus.req_valid = v;
        bus.flush     = fl;
    endtask

    task automatic set_unit(input int u, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        bus.req[u].tag  = tag;
        bus.req[u].data = data;
    endtask

    task automatic expect_bcast(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                                input logic [SRC_W-1:0] src, input int at_cyc);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.src  = src;
        e.cyc  = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        now = cyc;
    endtask

    task automatic clear_inputs();
        applyStimulus('0, 1'b0);
        for (int u = 0; u < NUM_REQ; u++) set_unit(u, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checkOutput(name, 32'(bus.bcast_valid), 32'd0);
    endtask

    // Scoreboard monitor: every broadcast must match the queue head, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [NUM_TAGS-1:0] onehot;
        if (!rst) begin
            if (bus.bcast_valid) begin
                if (exp_q.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL unexpected_bcast: got tag %0d src %0d at cycle %0d, expected no broadcast",
                             bus.bcast_tag, bus.bcast_src, cyc);
                end else begin
                    e = exp_q.pop_front();
                    onehot = '0;
                    onehot[e.tag] = 1'b1;
                    checkOutput("bcast_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("bcast_tag", 32'(bus.bcast_tag), 32'(e.tag));
                    checkOutput("bcast_data", bus.bcast_data, e.data);
                    checkOutput("bcast_src", 32'(bus.bcast_src), 32'(e.src));
                    checkOutput("cdb_enable", 32'(bus.cdb_enable), 32'(onehot));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                check_count++;
                $display("[TB] FAIL missing_bcast: got no broadcast at cycle %0d, expected tag %0d", cyc, exp_q[0].tag);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [NUM_REQ-1:0] t2_ready [4];
        t2_ready    = '{4'h1, 4'h3, 4'h7, 4'hF};
        check_count = 0;
        pass_count  = 0;
        now         = 0;
        rst         = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);

        checkOutput("rst_bcast_valid", 32'(bus.bcast_valid), 32'd0);
        checkOutput("rst_bcast_tag", 32'(bus.bcast_tag), 32'd0);
        checkOutput("rst_bcast_data", bus.bcast_data, 32'd0);
        checkOutput("rst_bcast_src", 32'(bus.bcast_src), 32'd0);
        checkOutput("rst_cdb_enable", 32'(bus.cdb_enable), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'hF);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        $display("[TB] single result from unit 2");
        base = now;
        set_unit(2, 3'd5, 32'h600D600D);
        applyStimulus(4'b0100, 1'b0);
        expect_bcast(3'd5, 32'h600D600D, 2'd2, base + 1);
        next_cycle();
        applyStimulus('0, 1'b0);
        @(negedge clk);
        checkOutput("t1_req_ready", 32'(bus.req_ready), 32'hF);
        next_cycle();
        check_idle("t1_idle_after");

        $display("[TB] all four units at once");
        do_reset();
        base = now;
        for (int u = 0; u < NUM_REQ; u++) begin
            set_unit(u, TAG_W'(u), 32'hA0 + 32'(u));
            expect_bcast(TAG_W'(u), 32'hA0 + 32'(u), SRC_W'(u), base + 1 + u);
        end
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            applyStimulus('0, 1'b0);
            @(negedge clk);
            checkOutput("t2_req_ready", 32'(bus.req_ready), 32'(t2_ready[k]));
        end
        next_cycle();
        check_idle("t2_idle_after");

        $display("[TB] unit 0 streaming, unit 1 once");
        do_reset();
        base = now;
        set_unit(0, 3'd0, 32'hB0);
        set_unit(1, 3'd7, 32'hB7);
        applyStimulus(4'b0011, 1'b0);
        expect_bcast(3'd0, 32'hB0, 2'd0, base + 1);
        expect_bcast(3'd7, 32'hB7, 2'd1, base + 2);
        expect_bcast(3'd1, 32'hB1, 2'd0, base + 3);
        expect_bcast(3'd2, 32'hB2, 2'd0, base + 4);
        next_cycle();
        set_unit(0, 3'd1, 32'hB1);
        applyStimulus(4'b0001, 1'b0);
        @(negedge clk);
        checkOutput("t3_ready_refill", 32'(bus.req_ready), 32'hD);
        next_cycle();
        set_unit(0, 3'd2, 32'hB2);
        @(negedge clk);
        checkOutput("t3_ready_stall", 32'(bus.req_ready), 32'hE);
        next_cycle();
        @(negedge clk);
        checkOutput("t3_ready_retry", 32'(bus.req_ready), 32'hF);
        next_cycle();
        applyStimulus('0, 1'b0);
        next_cycle();
        check_idle("t3_idle_after");

        $display("[TB] flush while slot 3 would be granted");
        do_reset();
        base = now;
        set_unit(0, 3'd0, 32'hD0);
        applyStimulus(4'b0001, 1'b0);
        expect_bcast(3'd0, 32'hD0, 2'd0, base + 1);
        next_cycle();
        set_unit(3, 3'd4, 32'hD4);
        applyStimulus(4'b1000, 1'b0);
        next_cycle();
        set_unit(2, 3'd7, 32'hD7);
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        checkOutput("t4_flush_valid", 32'(bus.bcast_valid), 32'd0);
        checkOutput("t4_flush_enable", 32'(bus.cdb_enable), 32'd0);
        next_cycle();
        set_unit(0, 3'd5, 32'hD5);
        set_unit(3, 3'd6, 32'hD6);
        applyStimulus(4'b1001, 1'b0);
        expect_bcast(3'd6, 32'hD6, 2'd3, base + 4);
        expect_bcast(3'd5, 32'hD5, 2'd0, base + 5);
        @(negedge clk);
        checkOutput("t4_after_flush_valid", 32'(bus.bcast_valid), 32'd0);
        checkOutput("t4_after_flush_ready", 32'(bus.req_ready), 32'hF);
        next_cycle();
        applyStimulus('0, 1'b0);
        next_cycle();
        next_cycle();
        check_idle("t4_idle_after");

        $display("[TB] refill of a granted slot");
        do_reset();
        base = now;
        set_unit(1, 3'd1, 32'hE1);
        applyStimulus(4'b0010, 1'b0);
        expect_bcast(3'd1, 32'hE1, 2'd1, base + 1);
        next_cycle();
        set_unit(1, 3'd6, 32'hE6);
        expect_bcast(3'd6, 32'hE6, 2'd1, base + 2);
        @(negedge clk);
        checkOutput("t5_ready_granted", 32'(bus.req_ready), 32'hF);
        next_cycle();
        applyStimulus('0, 1'b0);
        next_cycle();
        check_idle("t5_idle_after");

        $display("[TB] asynchronous reset with three slots held");
        do_reset();
        base = now;
        set_unit(0, 3'd2, 32'hF2);
        set_unit(1, 3'd3, 32'hF3);
        set_unit(2, 3'd4, 32'hF4);
        applyStimulus(4'b0111, 1'b0);
        expect_bcast(3'd2, 32'hF2, 2'd0, base + 1);
        next_cycle();
        applyStimulus('0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", 32'(bus.bcast_valid), 32'd0);
        checkOutput("t6_async_enable", 32'(bus.cdb_enable), 32'd0);
        checkOutput("t6_async_ready", 32'(bus.req_ready), 32'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check_idle("t6_idle_after_rst");
        end

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
